irrigation_elapsed_timer: RTL and testbench

- Elapsed-time counter for an irrigation cycle, displayed as MM:SS in BCD (range 00:00 to 39:59).
- Sits directly upstream of the timer reset logic: it produces the minutes-tens, minutes-units and seconds-tens digits that block monitors.
- Consumes the reset that block produces as a synchronous clear.
- Divides the system clock to a 1 Hz tick and counts only while irrigation is on.

---
 rtl/irrigation_elapsed_timer_pkg.sv | 21 ++
 rtl/irrigation_elapsed_timer_bcd_digit_counter.sv | 45 ++++
 rtl/irrigation_elapsed_timer.sv | 117 +++++++++++
 tb/tb_irrigation_elapsed_timer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/irrigation_elapsed_timer_pkg.sv
// -----------------------------------------------------------------------------
// irrigation_elapsed_timer_pkg
// Shared constants for the irrigation elapsed-time counter: the largest value
// of each BCD digit of the MM:SS display and the width of each digit field.
// No ports (package).
// -----------------------------------------------------------------------------
package irrigation_elapsed_timer_pkg;

    // Largest value each digit may hold before it wraps to 0
    localparam int SEC_U_MAX = 9;
    localparam int SEC_D_MAX = 5;
    localparam int MIN_U_MAX = 9;
    localparam int MIN_D_MAX = 3;

    // Digit field widths
    localparam int SEC_U_W = 4;
    localparam int SEC_D_W = 3;
    localparam int MIN_U_W = 4;
    localparam int MIN_D_W = 2;

endpackage : irrigation_elapsed_timer_pkg

// File: rtl/irrigation_elapsed_timer_bcd_digit_counter.sv
// -----------------------------------------------------------------------------
// bcd_digit_counter
// One digit of a decimal/sexagesimal carry chain. Counts 0..MAX on each
// increment and wraps to 0, raising carry on the increment that wraps.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   clear  in   synchronous clear, priority over inc
//   inc    in   advance the digit by one on this edge
//   value  out  current digit value
//   carry  out  inc AND value==MAX (combinational)
// -----------------------------------------------------------------------------
module bcd_digit_counter #(
    parameter int MAX = 9,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         carry
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] r_value;

    // ">=" rather than "==" so an out-of-range value recovers to 0 on the
    // next increment instead of running on through illegal codes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (clear) begin
            r_value <= '0;
        end else if (inc) begin
            r_value <= (r_value >= MAX_V) ? '0 : r_value + W'(1);
        end
    end

    assign value = r_value;
    assign carry = inc & (r_value == MAX_V);

endmodule : bcd_digit_counter

// File: rtl/irrigation_elapsed_timer.sv
// -----------------------------------------------------------------------------
// irrigation_elapsed_timer
// Elapsed time of an irrigation cycle as MM:SS BCD, 00:00 .. 39:59. The system
// clock is divided down to one counted second every TICK_DIV enabled clocks;
// the count saturates at 39:59 until cleared.
//
// Parameters:
//   TICK_DIV    system clocks per counted second (>= 2)
//   PRESCALE_W  prescaler width, 2**PRESCALE_W >= TICK_DIV
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   timer_clear    in   synchronous clear from the timer reset logic
//   count_en       in   irrigation on; counting advances only while high
//   seconds_u      out  seconds units 0..9
//   seconds_d      out  seconds tens 0..5
//   minutes_u      out  minutes units 0..9
//   minutes_d      out  minutes tens 0..3
//   second_tick    out  one-cycle pulse after each edge the time advanced
//   limit_reached  out  high while the display reads 39:59
// -----------------------------------------------------------------------------
module irrigation_elapsed_timer
    import irrigation_elapsed_timer_pkg::*;
#(
    parameter int TICK_DIV   = 50000000,
    parameter int PRESCALE_W = 26
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               timer_clear,
    input  logic               count_en,
    output logic [SEC_U_W-1:0] seconds_u,
    output logic [SEC_D_W-1:0] seconds_d,
    output logic [MIN_U_W-1:0] minutes_u,
    output logic [MIN_D_W-1:0] minutes_d,
    output logic               second_tick,
    output logic               limit_reached
);

    localparam logic [PRESCALE_W-1:0] PRE_TERM = PRESCALE_W'(TICK_DIV - 1);

    logic [PRESCALE_W-1:0] r_prescale;
    logic                  r_second_tick;

    logic [SEC_U_W-1:0] w_su;
    logic [SEC_D_W-1:0] w_sd;
    logic [MIN_U_W-1:0] w_mu;
    logic [MIN_D_W-1:0] w_md;
    logic w_su_carry, w_sd_carry, w_mu_carry, w_md_carry;
    logic w_tick_edge, w_limit, w_su_inc;
    logic w_sd_bad, w_mu_bad, w_sd_clear, w_mu_clear;

    // The prescaler holds while count_en is low so a pause loses no partial
    // second; it keeps wrapping once the digits have saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescale <= '0;
        end else if (timer_clear) begin
            r_prescale <= '0;
        end else if (count_en) begin
            r_prescale <= (r_prescale == PRE_TERM) ? '0 : r_prescale + PRESCALE_W'(1);
        end
    end

    assign w_tick_edge = count_en & ~timer_clear & (r_prescale == PRE_TERM);

    assign w_limit = (w_md == MIN_D_W'(MIN_D_MAX)) && (w_mu == MIN_U_W'(MIN_U_MAX)) &&
                     (w_sd == SEC_D_W'(SEC_D_MAX)) && (w_su == SEC_U_W'(SEC_U_MAX));

    assign w_su_inc = w_tick_edge & ~w_limit;

    // Higher digits only see inc through a carry, which an illegal lower digit
    // never produces, so an out-of-range digit is zeroed on any tick edge.
    assign w_sd_bad   = (w_sd > SEC_D_W'(SEC_D_MAX));
    assign w_mu_bad   = (w_mu > MIN_U_W'(MIN_U_MAX));
    assign w_sd_clear = timer_clear | (w_tick_edge & w_sd_bad);
    assign w_mu_clear = timer_clear | (w_tick_edge & w_mu_bad);

    bcd_digit_counter #(.MAX(SEC_U_MAX), .W(SEC_U_W)) u_sec_u (
        .clk(clk), .rst_n(rst_n), .clear(timer_clear),
        .inc(w_su_inc), .value(w_su), .carry(w_su_carry)
    );

    bcd_digit_counter #(.MAX(SEC_D_MAX), .W(SEC_D_W)) u_sec_d (
        .clk(clk), .rst_n(rst_n), .clear(w_sd_clear),
        .inc(w_su_carry), .value(w_sd), .carry(w_sd_carry)
    );

    bcd_digit_counter #(.MAX(MIN_U_MAX), .W(MIN_U_W)) u_min_u (
        .clk(clk), .rst_n(rst_n), .clear(w_mu_clear),
        .inc(w_sd_carry), .value(w_mu), .carry(w_mu_carry)
    );

    bcd_digit_counter #(.MAX(MIN_D_MAX), .W(MIN_D_W)) u_min_d (
        .clk(clk), .rst_n(rst_n), .clear(timer_clear),
        .inc(w_mu_carry), .value(w_md), .carry(w_md_carry)
    );

    // A carry out of the top digit would mean the display wrapped to 00:00;
    // saturation gating prevents it, and it must never be reported as a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_second_tick <= 1'b0;
        end else begin
            r_second_tick <= w_su_inc & ~w_md_carry;
        end
    end

    assign seconds_u     = w_su;
    assign seconds_d     = w_sd;
    assign minutes_u     = w_mu;
    assign minutes_d     = w_md;
    assign second_tick   = r_second_tick;
    assign limit_reached = w_limit;

endmodule : irrigation_elapsed_timer

// File: tb/tb_irrigation_elapsed_timer.sv
// -----------------------------------------------------------------------------
// tb_irrigation_elapsed_timer
// Scoreboard bench for irrigation_elapsed_timer with TICK_DIV=4. The driver
// updates a total-seconds reference model per clock and queues the expected
// outputs; a monitor pops and compares them just after each rising edge.
// -----------------------------------------------------------------------------
module tb_irrigation_elapsed_timer;

    localparam int TICK_DIV   = 4;
    localparam int PRESCALE_W = 3;
    localparam int SAT_SECS   = 39 * 60 + 59;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       timer_clear = 1'b0;
    logic       count_en = 1'b0;
    logic [3:0] seconds_u;
    logic [2:0] seconds_d;
    logic [3:0] minutes_u;
    logic [1:0] minutes_d;
    logic       second_tick;
    logic       limit_reached;

    irrigation_elapsed_timer #(
        .TICK_DIV(TICK_DIV),
        .PRESCALE_W(PRESCALE_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .timer_clear(timer_clear),
        .count_en(count_en),
        .seconds_u(seconds_u),
        .seconds_d(seconds_d),
        .minutes_u(minutes_u),
        .minutes_d(minutes_d),
        .second_tick(second_tick),
        .limit_reached(limit_reached)
    );

    always #5 clk = ~clk;

    // Expected entry: {digits[12:0], second_tick, limit_reached}
    logic [14:0] sb[$];

    int vectors     = 0;
    int miscompares = 0;

    int m_secs = 0;
    int m_pre  = 0;

    task automatic expect_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [12:0] digits_of(input int secs);
        return {2'(secs / 600), 4'((secs / 60) % 10), 3'((secs / 10) % 6), 4'(secs % 10)};
    endfunction

    function automatic logic [12:0] dut_digits();
        return {minutes_d, minutes_u, seconds_d, seconds_u};
    endfunction

    // One clock: drive inputs at the falling edge, advance the model, queue
    // what the DUT must show after the next rising edge.
    task automatic step(input logic en, input logic clr);
        logic tick;
        @(negedge clk);
        count_en    = en;
        timer_clear = clr;
        tick = 1'b0;
        if (clr) begin
            m_pre  = 0;
            m_secs = 0;
        end else if (en) begin
            if (m_pre == TICK_DIV - 1) begin
                m_pre = 0;
                if (m_secs < SAT_SECS) begin
                    m_secs++;
                    tick = 1'b1;
                end
            end else begin
                m_pre++;
            end
        end
        sb.push_back({digits_of(m_secs), tick, (m_secs == SAT_SECS)});
    endtask

    // Pull rst_n low between edges and check the outputs clear at once.
    task automatic async_reset_mid_cycle(input string tag);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        expect_eq({tag, "_digits"}, 16'(dut_digits()), 16'd0);
        expect_eq({tag, "_tick"}, 16'(second_tick), 16'd0);
        expect_eq({tag, "_limit"}, 16'(limit_reached), 16'd0);
        m_secs = 0;
        m_pre  = 0;
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        logic [14:0] e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            expect_eq("digits", 16'(dut_digits()), 16'(e[14:2]));
            expect_eq("second_tick", 16'(second_tick), 16'(e[1]));
            expect_eq("limit_reached", 16'(limit_reached), 16'(e[0]));
        end
    end

    initial begin
        // Power-on reset
        #12;
        expect_eq("por_digits", 16'(dut_digits()), 16'd0);
        expect_eq("por_tick", 16'(second_tick), 16'd0);
        expect_eq("por_limit", 16'(limit_reached), 16'd0);
        #1 rst_n = 1'b1;

        // Async reset mid-count at 00:07, then first tick after 4 enabled clocks
        while (!(m_secs == 7 && m_pre == 2)) step(1'b1, 1'b0);
        async_reset_mid_cycle("arst");
        repeat (6) step(1'b1, 1'b0);

        // Clear coinciding with the tick out of 00:09
        while (!(m_secs == 9 && m_pre == TICK_DIV - 1)) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (2) step(1'b1, 1'b0);

        // Pause with the prescaler at 2, then resume
        while (m_pre != 2) step(1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0);

        // Cascade 00:59 -> 01:00, then 09:59 -> 10:00
        while (m_secs < 59) step(1'b1, 1'b0);
        while (m_secs < 61) step(1'b1, 1'b0);
        while (m_secs < 600) step(1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0);

        // Run to saturation, then 12 more enabled clocks
        while (m_secs < SAT_SECS) step(1'b1, 1'b0);
        repeat (12) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);

        // Clear from saturation, restart counting
        step(1'b1, 1'b1);
        repeat (6) step(1'b1, 1'b0);

        // Clear held high keeps 00:00
        repeat (5) step(1'b1, 1'b1);
        repeat (5) step(1'b1, 1'b0);

        @(posedge clk);
        #3;
        expect_eq("sb_drain", 16'(sb.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_irrigation_elapsed_timer
